corr_peak_search: RTL and testbench
===================================

# corr_peak_search

Parametrised correlation peak-search controller for the camera pipeline. After a frame is stored, it raster-scans a configurable search window with configurable X/Y steps. For each point it issues a start pulse to the correlator and waits for the correlation result. It tracks the maximum result and publishes its coordinates and value once the scan completes. Abort and restart are supported, and published results stay stable while a new scan runs.

## Interface
- COORD_W, 13: width of all coordinate ports and counters
- CORR_W, 32: width of correlation values (unsigned)
- X_MIN, 0 / X_MAX, 639: inclusive X bounds of the search window
- Y_MIN, 0 / Y_MAX, 479: inclusive Y bounds of the search window
- X_STEP, 1 / Y_STEP, 1: scan increments (≥1)

Ports:
- iCLK  in  1  system clock; all logic on its rising edge
- iRST  in  1  reset, synchronous, active-low
- iStart  in  1  one-cycle pulse: frame saved, begin scan (honoured only in IDLE)
- iAbort  in  1  level/pulse: abandon the current scan
- oCorrStart  out  1  one-cycle pulse: correlate at oX/oY
- oX, oY  out  COORD_W  current point; stable from oCorrStart until the matching iCorrValid
- iCorrValid  in  1  one-cycle pulse: iCorr holds the result for the current point
- iCorr  in  CORR_W  correlation value, unsigned
- oBusy  out  1  high in every state except IDLE
- oDone  out  1  one-cycle pulse: scan complete, results updated
- oXresult, oYresult  out  COORD_W  coordinates of the peak from the last completed scan
- oPeakCorr  out  CORR_W  peak value from the last completed scan
- oPeakValid  out  1  high once any scan has completed; cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On iStart: load X=X_MIN, Y=Y_MIN, clear the working best (best_valid=0), then go to ISSUE.
  - iStart in any other state is ignored.
- **ISSUE**: assert oCorrStart for exactly one cycle, then go to WAIT.
- **WAIT**
  - On iCorrValid, compare with the working best.
  - Replace the working best (value, X, Y) if best_valid=0 or iCorr > best.
  - Use strict greater-than, so on a tie the earliest point in raster order wins.
  - Then either advance to the next point and go to ISSUE, or, if this was the last point, go to DONE.
  - iCorrValid outside WAIT is ignored.
- **Advance**
  - Compute in COORD_W+1 bits so there is no overflow at the top of range.
  - If X+X_STEP ≤ X_MAX, set X += X_STEP.
  - Otherwise set X = X_MIN and Y += Y_STEP.
  - The last point is reached when X+X_STEP > X_MAX and Y+Y_STEP > Y_MAX.
  - X_MAX and Y_MAX are not necessarily visited; the last X column is X_MIN + k·X_STEP ≤ X_MAX.
- **DONE**
  - Copy the working best to oXresult, oYresult and oPeakCorr.
  - Set oPeakValid=1 and pulse oDone for one cycle, then go to IDLE.
- **Abort**
  - iAbort in ISSUE, WAIT or DONE-entry returns to IDLE on the next edge.
  - No oDone is generated, and published results are unchanged.
  - A correlator response arriving after abort is ignored.
  - iAbort has priority over iCorrValid in the same cycle.
- Published outputs change only in DONE and never mid-scan.

## Timing
- Reset values (iRST=0 at an edge):
  - state=IDLE; oX=X_MIN, oY=Y_MIN.
  - oCorrStart=0, oBusy=0, oDone=0, oPeakValid=0.
  - oXresult=0, oYresult=0, oPeakCorr=0.
  - Reset mid-scan discards all progress.
- iStart sampled at edge n:
  - oBusy=1 and state ISSUE at n+1.
  - oCorrStart=1 during n+1→n+2.
- iCorrValid at edge m (in WAIT): the next oCorrStart is high from m+1 with the new oX/oY, i.e. 2 cycles per point plus correlator latency.
- iCorrValid at the last point, edge m:
  - DONE at m+1; oDone and the new results are visible from m+2 (oDone high for one cycle).
  - oBusy falls at m+2.
- Correlator latency of zero (iCorrValid in the first WAIT cycle) must work.
- No timeout: WAIT holds indefinitely.

## Test plan
1. **Basic scan.** Params X 0..3, Y 0..2, step 1; model returns 10·(X+1)+Y except (2,1)=999.
   - Expect 12 oCorrStart pulses in raster order.
   - Expect one oDone, oXresult=2, oYresult=1, oPeakCorr=999, oPeakValid=1.
2. **Tie.** All points return 50.
   - Expect result (0,0), oPeakCorr=50.
   - Then rerun with (3,2)=60 and expect the result to move to (3,2).
3. **Step.** X 0..5 step 2, Y 1..4 step 3.
   - Expect points (0,1),(2,1),(4,1),(0,4),(2,4),(4,4), exactly 6 pulses.
   - Expect oDone after the 6th response.
4. **Abort.** Scan #1 completes with peak (1,1). Scan #2 is aborted in WAIT at its 5th point.
   - Expect oBusy=0 next cycle, no oDone.
   - Expect results still (1,1); a late iCorrValid is ignored.
5. **Busy/stray inputs.** Pulse iStart mid-scan and iCorrValid in IDLE.
   - Expect no effect; the point count stays 12.
6. **Reset.** Assert iRST=0 mid-scan after one completed scan.
   - Expect all outputs at their reset values, including oPeakValid=0.
   - Then a zero-latency correlator run completes at 2 cycles per point.

Source files
------------

// File: rtl/corr_peak_search.sv
`default_nettype none
// ============================================================================
//  Module   : corr_peak_search
//  Purpose  : Raster-scans a search window, requests one correlation per
//             point, tracks the strict maximum and publishes its location
//             and value when the scan completes. Abort/restart supported;
//             published results only change at scan completion.
//  Revision : 1.0  initial release
// ============================================================================
module corr_peak_search #(
    parameter int COORD_W = 13,
    parameter int CORR_W  = 32,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 639,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 479,
    parameter int X_STEP  = 1,
    parameter int Y_STEP  = 1
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iStart,
    input  logic               iAbort,
    output logic               oCorrStart,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    input  logic               iCorrValid,
    input  logic [CORR_W-1:0]  iCorr,
    output logic               oBusy,
    output logic               oDone,
    output logic [COORD_W-1:0] oXresult,
    output logic [COORD_W-1:0] oYresult,
    output logic [CORR_W-1:0]  oPeakCorr,
    output logic               oPeakValid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Window bounds; the advance arithmetic uses one extra bit so that
    // X+X_STEP cannot wrap at the top of the coordinate range.
    localparam logic [COORD_W-1:0] c_X_MIN    = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] c_Y_MIN    = COORD_W'(Y_MIN);
    localparam logic [COORD_W:0]   c_X_MAX_E  = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0]   c_Y_MAX_E  = (COORD_W+1)'(Y_MAX);
    localparam logic [COORD_W:0]   c_X_STEP_E = (COORD_W+1)'(X_STEP);
    localparam logic [COORD_W:0]   c_Y_STEP_E = (COORD_W+1)'(Y_STEP);

    state_t               state_q,  state_d;
    logic [COORD_W-1:0]   x_q,      x_d;
    logic [COORD_W-1:0]   y_q,      y_d;
    logic [CORR_W-1:0]    best_q,   best_d;
    logic [COORD_W-1:0]   bx_q,     bx_d;
    logic [COORD_W-1:0]   by_q,     by_d;
    logic                 bvalid_q, bvalid_d;
    logic [COORD_W-1:0]   xres_q,   xres_d;
    logic [COORD_W-1:0]   yres_q,   yres_d;
    logic [CORR_W-1:0]    peak_q,   peak_d;
    logic                 pvalid_q, pvalid_d;
    logic                 done_q,   done_d;

    logic [COORD_W:0]     x_next_e;
    logic [COORD_W:0]     y_next_e;
    logic                 x_wrap;
    logic                 y_wrap;
    logic                 take;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state_q  <= S_IDLE;
            x_q      <= c_X_MIN;
            y_q      <= c_Y_MIN;
            best_q   <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            bvalid_q <= 1'b0;
            xres_q   <= '0;
            yres_q   <= '0;
            peak_q   <= '0;
            pvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            best_q   <= best_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            bvalid_q <= bvalid_d;
            xres_q   <= xres_d;
            yres_q   <= yres_d;
            peak_q   <= peak_d;
            pvalid_q <= pvalid_d;
            done_q   <= done_d;
        end
    end

    // Next-state, scan advance, best tracking and result publication
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        best_d   = best_q;
        bx_d     = bx_q;
        by_d     = by_q;
        bvalid_d = bvalid_q;
        xres_d   = xres_q;
        yres_d   = yres_q;
        peak_d   = peak_q;
        pvalid_d = pvalid_q;
        done_d   = 1'b0;

        x_next_e = {1'b0, x_q} + c_X_STEP_E;
        y_next_e = {1'b0, y_q} + c_Y_STEP_E;
        x_wrap   = (x_next_e > c_X_MAX_E);
        y_wrap   = (y_next_e > c_Y_MAX_E);
        // Strict compare: on ties the earliest raster point is kept
        take     = !bvalid_q || (iCorr > best_q);

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    x_d      = c_X_MIN;
                    y_d      = c_Y_MIN;
                    bvalid_d = 1'b0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = iAbort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (iAbort) begin
                    state_d = S_IDLE;
                end else if (iCorrValid) begin
                    if (take) begin
                        best_d   = iCorr;
                        bx_d     = x_q;
                        by_d     = y_q;
                        bvalid_d = 1'b1;
                    end
                    if (x_wrap && y_wrap) begin
                        state_d = S_DONE;
                    end else begin
                        if (x_wrap) begin
                            x_d = c_X_MIN;
                            y_d = y_next_e[COORD_W-1:0];
                        end else begin
                            x_d = x_next_e[COORD_W-1:0];
                        end
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!iAbort) begin
                    xres_d   = bx_q;
                    yres_d   = by_q;
                    peak_d   = best_q;
                    pvalid_d = 1'b1;
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign oCorrStart = (state_q == S_ISSUE);
    assign oBusy      = (state_q != S_IDLE);
    assign oX         = x_q;
    assign oY         = y_q;
    assign oDone      = done_q;
    assign oXresult   = xres_q;
    assign oYresult   = yres_q;
    assign oPeakCorr  = peak_q;
    assign oPeakValid = pvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_corr_peak_search.sv
`default_nettype none
// ============================================================================
//  Module   : tb_corr_peak_search
//  Purpose  : Self-checking bench for corr_peak_search. Two instances: a
//             4x3 unit-step window and a 6x4 window with steps 2/3. A
//             behavioural correlator/reference model drives and checks them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_corr_peak_search;

    logic iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    logic        rst_n;
    logic        start;
    logic        abort;
    logic        cvalid;
    logic [31:0] corr;
    bit          sel;

    logic        cs_a, busy_a, done_a, pv_a, cs_b, busy_b, done_b, pv_b;
    logic [12:0] x_a, y_a, xr_a, yr_a, x_b, y_b, xr_b, yr_b;
    logic [31:0] pk_a, pk_b;

    wire start_a  = start  & ~sel;
    wire start_b  = start  &  sel;
    wire abort_a  = abort  & ~sel;
    wire abort_b  = abort  &  sel;
    wire cvalid_a = cvalid & ~sel;
    wire cvalid_b = cvalid &  sel;

    corr_peak_search #(.COORD_W(13), .CORR_W(32), .X_MIN(0), .X_MAX(3),
        .Y_MIN(0), .Y_MAX(2), .X_STEP(1), .Y_STEP(1)) dut_a (
        .iCLK(iCLK), .iRST(rst_n), .iStart(start_a), .iAbort(abort_a),
        .oCorrStart(cs_a), .oX(x_a), .oY(y_a), .iCorrValid(cvalid_a),
        .iCorr(corr), .oBusy(busy_a), .oDone(done_a), .oXresult(xr_a),
        .oYresult(yr_a), .oPeakCorr(pk_a), .oPeakValid(pv_a));

    corr_peak_search #(.COORD_W(13), .CORR_W(32), .X_MIN(0), .X_MAX(5),
        .Y_MIN(1), .Y_MAX(4), .X_STEP(2), .Y_STEP(3)) dut_b (
        .iCLK(iCLK), .iRST(rst_n), .iStart(start_b), .iAbort(abort_b),
        .oCorrStart(cs_b), .oX(x_b), .oY(y_b), .iCorrValid(cvalid_b),
        .iCorr(corr), .oBusy(busy_b), .oDone(done_b), .oXresult(xr_b),
        .oYresult(yr_b), .oPeakCorr(pk_b), .oPeakValid(pv_b));

    wire        cs   = sel ? cs_b   : cs_a;
    wire        busy = sel ? busy_b : busy_a;
    wire        done = sel ? done_b : done_a;
    wire        pv   = sel ? pv_b   : pv_a;
    wire [12:0] ox   = sel ? x_b    : x_a;
    wire [12:0] oy   = sel ? y_b    : y_a;
    wire [12:0] xr   = sel ? xr_b   : xr_a;
    wire [12:0] yr   = sel ? yr_b   : yr_a;
    wire [31:0] pk   = sel ? pk_b   : pk_a;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;
    int dones  = 0;

    // Expected published state (bench-side)
    int exp_xr = 0, exp_yr = 0, exp_pv = 0;
    longint exp_pk = 0;

    // Free-running counters of cycles, correlator requests and done pulses
    always @(posedge iCLK) begin
        cyc <= cyc + 1;
        if (cs)   pulses <= pulses + 1;
        if (done) dones  <= dones + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_val(input int mode, input int x, input int y);
        case (mode)
            0: return (x == 2 && y == 1) ? 999 : 10 * (x + 1) + y;
            1: return 50;
            2: return (x == 3 && y == 2) ? 60 : 50;
            3: return longint'($urandom_range(0, 7));
            4: return (x == 1 && y == 1) ? 500 : x + y;
            5: return 1000 + x + y;
            default: return x * y + 3;
        endcase
    endfunction

    task automatic chk_published(input string tag);
        chk({tag, "_xres"}, 64'(xr), 64'(exp_xr));
        chk({tag, "_yres"}, 64'(yr), 64'(exp_yr));
        chk({tag, "_peak"}, 64'(pk), 64'(exp_pk));
        chk({tag, "_pvalid"}, 64'(pv), 64'(exp_pv));
    endtask

    // One scan: request/response loop driven by the correlator model.
    // abort_at / stray_at / rst_at select a point index (-1 = never).
    task automatic run_scan(input int s, input int mode, input int maxlat,
                            input int abort_at, input int stray_at, input int rst_at);
        int px[$];
        int py[$];
        int xmin, xmax, xs, ymin, ymax, ys, n, c0, p0, d0, w, lat;
        int bx, by;
        longint best, v;
        bit have;
        if (s == 0) begin xmin = 0; xmax = 3; xs = 1; ymin = 0; ymax = 2; ys = 1; end
        else        begin xmin = 0; xmax = 5; xs = 2; ymin = 1; ymax = 4; ys = 3; end
        for (int y = ymin; y <= ymax; y += ys)
            for (int x = xmin; x <= xmax; x += xs) begin
                px.push_back(x);
                py.push_back(y);
            end
        n = px.size();
        have = 1'b0; best = 0; bx = 0; by = 0;
        sel = s[0];
        p0 = pulses; d0 = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!cs && w < 50) begin tick(); w++; end
            chk("corr_start_seen", 64'(cs), 64'd1);
            if (!cs) return;
            chk("point_x", 64'(ox), 64'(px[i]));
            chk("point_y", 64'(oy), 64'(py[i]));
            if (i == rst_at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                return;
            end
            tick();
            if (i == stray_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            lat = (maxlat > 0) ? int'($urandom_range(0, maxlat)) : 0;
            repeat (lat) tick();
            if (i == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_idle", 64'(busy), 64'd0);
                return;
            end
            v = model_val(mode, px[i], py[i]);
            cvalid = 1'b1;
            corr = 32'(v);
            tick();
            cvalid = 1'b0;
            if (!have || v > best) begin
                have = 1'b1; best = v; bx = px[i]; by = py[i];
            end
            if (i < n - 1) chk("next_issue", 64'(cs), 64'd1);
        end
        chk("done_state_busy", 64'(busy), 64'd1);
        chk("done_not_yet", 64'(done), 64'd0);
        tick();
        exp_xr = bx; exp_yr = by; exp_pk = best; exp_pv = 1;
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_fall", 64'(busy), 64'd0);
        chk_published("scan");
        chk("pulse_count", 64'(pulses - p0), 64'(n));
        if (maxlat == 0 && stray_at < 0)
            chk("zero_lat_cycles", 64'(cyc - c0), 64'(2 * n + 1));
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("done_count", 64'(dones - d0), 64'd1);
    endtask

    task automatic chk_reset_values();
        chk("rst_corr_start", 64'(cs), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_x", 64'(ox), 64'd0);
        chk("rst_y", 64'(oy), 64'd0);
        exp_xr = 0; exp_yr = 0; exp_pk = 0; exp_pv = 0;
        chk_published("rst");
    endtask

    initial begin
        int d0, p0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cvalid = 1'b0; corr = '0; sel = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk_reset_values();

        // Basic scan, peak at (2,1)=999
        run_scan(0, 0, 3, -1, -1, -1);
        chk("basic_x", 64'(xr), 64'd2);
        chk("basic_y", 64'(yr), 64'd1);
        chk("basic_peak", 64'(pk), 64'd999);

        // Ties keep the first point; then a unique max at the last point
        run_scan(0, 1, 2, -1, -1, -1);
        chk("tie_x", 64'(xr), 64'd0);
        chk("tie_y", 64'(yr), 64'd0);
        run_scan(0, 2, 2, -1, -1, -1);
        chk("tie2_x", 64'(xr), 64'd3);
        chk("tie2_y", 64'(yr), 64'd2);

        // Stepped window: 6 points, peak at (4,4)
        run_scan(1, 6, 2, -1, -1, -1);
        chk("step_x", 64'(xr), 64'd4);
        chk("step_y", 64'(yr), 64'd4);
        sel = 1'b0;

        // Random values with many ties
        for (int k = 0; k < 4; k++) run_scan(0, 3, 3, -1, -1, -1);

        // Abort: results from scan #1 must survive an aborted scan #2
        run_scan(0, 4, 2, -1, -1, -1);
        d0 = dones; p0 = pulses;
        run_scan(0, 5, 2, 4, -1, -1);
        cvalid = 1'b1; corr = 32'hFFFF_FFFF;
        tick();
        cvalid = 1'b0;
        tick(); tick();
        chk("abort_late_busy", 64'(busy), 64'd0);
        chk("abort_no_done", 64'(dones - d0), 64'd0);
        chk("abort_pulses", 64'(pulses - p0), 64'd5);
        chk_published("abort");
        chk("abort_keep_x", 64'(xr), 64'd1);
        chk("abort_keep_y", 64'(yr), 64'd1);

        // Stray iStart mid-scan and stray iCorrValid in IDLE
        run_scan(0, 3, 2, -1, 3, -1);
        d0 = dones;
        cvalid = 1'b1; corr = 32'hFFFF_FFFF;
        tick();
        cvalid = 1'b0;
        tick();
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_no_done", 64'(dones - d0), 64'd0);
        chk_published("stray");

        // Reset mid-scan after a completed scan, then zero-latency run
        run_scan(0, 0, 1, -1, -1, -1);
        run_scan(0, 5, 1, -1, -1, 5);
        chk_reset_values();
        run_scan(0, 0, 0, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
